mux_sequencer: RTL and testbench
================================

Name: mux_sequencer

Overview:
- Parametrised successor to the switch-driven column multiplexing on the board top.
- Generates NB_MUX one-hot multiplexer enables for the LED panel. Each switch inserts a break-before-make blanking gap, so two mux lines are never driven together.
- Sits between driver_controller (column_ready) and the mux GPIO pins.
- Three modes: off, manual (one-hot from board switches), auto (advances one line per column_ready, re-aligns on position_sync).

Parameters:
- NB_MUX, 8, number of multiplexer lines (2..32).
- BLANKING_CYCLES, 72, dead cycles with all lines off on every line change (>=1).
- IDX_W, $clog2(NB_MUX), index width (derived, not overridden).

Ports:
- clk  in  1  main clock (66 MHz domain).
- rst  in  1  asynchronous, active-high reset.
- mode  in  2  0=OFF, 1=MANUAL, 2=AUTO, 3=reserved (treated as OFF).
- manual_sel  in  NB_MUX  requested line pattern in MANUAL mode.
- column_ready  in  1  single-cycle pulse: advance to next line (AUTO).
- position_sync  in  1  level; rising edge re-aligns the sequence to line 0.
- mux_out  out  NB_MUX  registered mux enables, one-hot or zero.
- mux_index  out  IDX_W  index of the active line (valid when mux_out!=0).
- blanking  out  1  high while in the break-before-make gap.
- frame_start  out  1  one-cycle pulse when line 0 becomes active in AUTO.

Behaviour:
- Reset (async, rst=1):
  - mux_out=0, mux_index=0, blanking=0, frame_start=0.
  - State OFF, blank counter 0, sync-pending flag 0, position_sync edge register 0.
- All outputs are registered. mode is sampled every cycle.
- States:
  - OFF: mux_out=0.
    - mode becomes MANUAL or AUTO -> BLANK with target = mode-specific line (see below).
  - BLANK: mux_out=0, blanking=1, counter counts up to BLANKING_CYCLES-1.
    - On the cycle after the terminal count: mux_out = one-hot(target), mux_index=target, blanking=0 -> ACTIVE.
  - ACTIVE: mux_out held.
    - Any line change request -> BLANK, counter cleared. mux_out goes to 0 on the next edge.
- Total latency from a request to the new line on: BLANKING_CYCLES+1 cycles.
- MANUAL mode:
  - Target = index of the lowest set bit of manual_sel.
  - manual_sel==0: mux_out=0 and state ACTIVE with no line, i.e. all lines off, no blanking needed.
  - Multiple bits set: the lowest wins, so mux_out is always one-hot.
  - Change detection compares the resolved target against mux_index, so a change in non-winning bits is ignored.
- AUTO mode:
  - Entry from OFF/MANUAL: target=0.
  - column_ready in ACTIVE: target = mux_index+1. NB_MUX-1 wraps to 0.
  - column_ready during BLANK: ignored and not queued. Drop-count behaviour is not required.
  - position_sync rising edge (detected internally, 1-cycle registered) sets sync_pending.
    - The next column_ready uses target=0 instead of index+1, then clears sync_pending.
    - A position_sync edge and column_ready in the same cycle: target=0.
  - frame_start pulses on the cycle mux_out becomes one-hot(0) in AUTO.
- Mode change at any time, including mid-BLANK:
  - To OFF: mux_out=0, blanking=0 on the next edge; counter and sync_pending cleared.
  - Between MANUAL and AUTO: restart BLANK with the counter cleared and the new target.
- mode==3 behaves exactly as OFF.
- Reset mid-BLANK or mid-ACTIVE: immediate return to reset values. No glitch on mux_out, which is driven only from flops.
- Invariant, checked by assertion: $onehot0(mux_out) every cycle. mux_out!=0 implies blanking==0.

Decomposition:
- Shared package spirose_pkg:
  - typedef mux_mode_e {MUX_OFF, MUX_MANUAL, MUX_AUTO, MUX_RSVD} (2 bits).
  - Default constant MUX_BLANKING_CYCLES=72, reused by driver_controller's BLANKING_TIME.
- One natural sub-module, priority_onehot_enc: NB_MUX-bit lowest-set-bit encoder returning index and valid. It is purely combinational and reused by the manual path.
- FSM, counter and sync logic stay in mux_sequencer.

Test Plan:
- Reset, then mode=AUTO, BLANKING_CYCLES=4 -> mux_out=0, blanking=1 for 4 cycles, then mux_out=8'h01, mux_index=0, frame_start=1 for one cycle.
- AUTO: 8 column_ready pulses spaced 10 cycles apart -> sequence 01,02,04,...,80,01. Each step is preceded by exactly 4 zero cycles. frame_start fires on the wrap to 01.
- AUTO at line 5, position_sync rises, then column_ready -> next line is 0 (mux_out=8'h01), not 6. Same-cycle sync and column_ready also yields 0.
- MANUAL: manual_sel=8'b0110_0000 -> mux_out=8'h20 after 5 cycles. Changing to 8'b0100_0000 -> 4 blank cycles then 8'h40. manual_sel=0 -> mux_out=0.
- column_ready during BLANK -> ignored; index advances by one only. Mode to OFF mid-BLANK -> mux_out=0, blanking=0 next cycle.
- Async rst asserted mid-ACTIVE between clock edges -> outputs zero immediately. $onehot0(mux_out) assertion holds across a random mode/column_ready/sync run of 10k cycles.

Source files
------------

// File: rtl/mux_sequencer_pkg.sv
// Shared types and defaults for the LED panel multiplexer sequencer.
//   mux_mode_e          : operating mode as driven on the 2-bit mode input.
//   seq_state_e         : sequencer FSM state, also exported for debug.
//   MUX_BLANKING_CYCLES : default break-before-make gap. driver_controller
//                         reuses it as its BLANKING_TIME.
package mux_sequencer_pkg;

  typedef enum logic [1:0] {
    MUX_OFF    = 2'd0,
    MUX_MANUAL = 2'd1,
    MUX_AUTO   = 2'd2,
    MUX_RSVD   = 2'd3
  } mux_mode_e;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_BLANK  = 2'd1,
    ST_ACTIVE = 2'd2
  } seq_state_e;

  localparam int MUX_BLANKING_CYCLES = 72;

endpackage

// File: rtl/mux_sequencer_if.sv
// Control/status bundle between the panel driver side and the mux sequencer.
//   mode          : 0=OFF, 1=MANUAL, 2=AUTO, 3=reserved (acts as OFF)
//   manual_sel    : requested line pattern in MANUAL mode (lowest set bit wins)
//   column_ready  : single-cycle pulse; no ready/backpressure exists. A pulse
//                   is consumed only when the sequencer is showing a line in
//                   AUTO mode, otherwise it is dropped.
//   position_sync : level; its rising edge re-aligns AUTO to line 0
//   mux_out       : registered one-hot-or-zero mux enables
//   mux_index     : index of the lit line (meaningful while mux_out != 0)
//   blanking      : high during the break-before-make gap
//   frame_start   : one-cycle pulse when line 0 lights in AUTO
//   dbg_state     : current sequencer FSM state (seq_state_e encoding)
interface mux_sequencer_if #(
  parameter int NB_MUX = 8
);
  localparam int IDX_W = $clog2(NB_MUX);

  logic [1:0]        mode;
  logic [NB_MUX-1:0] manual_sel;
  logic              column_ready;
  logic              position_sync;
  logic [NB_MUX-1:0] mux_out;
  logic [IDX_W-1:0]  mux_index;
  logic              blanking;
  logic              frame_start;
  logic [1:0]        dbg_state;

  modport master (
    output mode, manual_sel, column_ready, position_sync,
    input  mux_out, mux_index, blanking, frame_start, dbg_state
  );

  modport slave (
    input  mode, manual_sel, column_ready, position_sync,
    output mux_out, mux_index, blanking, frame_start, dbg_state
  );

endinterface

// File: rtl/mux_sequencer_priority_onehot_enc.sv
// Lowest-set-bit encoder, purely combinational.
//   vec   : input pattern
//   idx   : index of the lowest set bit (0 when vec is zero)
//   valid : vec has at least one bit set
module priority_onehot_enc #(
  parameter int W     = 8,
  parameter int IDX_W = $clog2(W)
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last to write idx.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sequencer.sv
// Break-before-make multiplexer sequencer for the LED panel.
// Drives NB_MUX one-hot line enables. Every line change passes through
// BLANKING_CYCLES dead cycles with all lines off.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : mux_sequencer_if slave (mode/select/pulse inputs, registered
//              mux enables and status outputs, debug state)
module mux_sequencer
  import mux_sequencer_pkg::*;
#(
  parameter int NB_MUX          = 8,
  parameter int BLANKING_CYCLES = MUX_BLANKING_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  mux_sequencer_if.slave  bus
);

  localparam int IDX_W = $clog2(NB_MUX);
  localparam int CNT_W = (BLANKING_CYCLES > 1) ? $clog2(BLANKING_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BLANK_TERM = CNT_W'(BLANKING_CYCLES - 1);

  seq_state_e        state_q, state_d;
  mux_mode_e         cur_mode_q, cur_mode_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  target_q, target_d;
  logic              sync_pending_q, sync_pending_d;
  logic              sync_q, sync_d;
  logic [NB_MUX-1:0] mux_out_q, mux_out_d;
  logic [IDX_W-1:0]  mux_index_q, mux_index_d;
  logic              blanking_q, blanking_d;
  logic              frame_start_q, frame_start_d;

  mux_mode_e         mode_eff;
  logic [IDX_W-1:0]  enc_idx;
  logic              enc_valid;
  logic              sync_edge;
  logic              line_on;
  logic              entering;
  logic              req;
  logic              go_dark;
  logic [IDX_W-1:0]  req_tgt;
  logic [IDX_W-1:0]  next_idx;

  priority_onehot_enc #(
    .W     (NB_MUX),
    .IDX_W (IDX_W)
  ) u_enc (
    .vec   (bus.manual_sel),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  always_comb begin
    case (mux_mode_e'(bus.mode))
      MUX_MANUAL: mode_eff = MUX_MANUAL;
      MUX_AUTO:   mode_eff = MUX_AUTO;
      default:    mode_eff = MUX_OFF;
    endcase
  end

  assign sync_edge = bus.position_sync & ~sync_q;
  assign line_on   = |mux_out_q;
  assign next_idx  = (mux_index_q == IDX_W'(NB_MUX - 1)) ? '0 : mux_index_q + IDX_W'(1);

  always_comb begin
    state_d        = state_q;
    cur_mode_d     = cur_mode_q;
    cnt_d          = cnt_q;
    target_d       = target_q;
    sync_pending_d = sync_pending_q;
    sync_d         = bus.position_sync;
    mux_out_d      = mux_out_q;
    mux_index_d    = mux_index_q;
    blanking_d     = blanking_q;
    frame_start_d  = 1'b0;
    entering       = 1'b0;
    req            = 1'b0;
    go_dark        = 1'b0;
    req_tgt        = '0;

    if (mode_eff == MUX_OFF) begin
      state_d        = ST_OFF;
      cur_mode_d     = MUX_OFF;
      cnt_d          = '0;
      sync_pending_d = 1'b0;
      mux_out_d      = '0;
      blanking_d     = 1'b0;
    end else begin
      // A mode switch (including leaving OFF) restarts the sequence.
      entering   = (state_q == ST_OFF) || (cur_mode_q != mode_eff);
      cur_mode_d = mode_eff;

      if (mode_eff == MUX_MANUAL) begin
        sync_pending_d = 1'b0;
        req_tgt        = enc_idx;
        if (!enc_valid) begin
          // No line requested: dark immediately, nothing to blank for.
          go_dark = 1'b1;
        end else if (entering) begin
          req = 1'b1;
        end else if (state_q == ST_BLANK) begin
          req = (enc_idx != target_q);
        end else begin
          // Compare the resolved winner, so non-winning bit changes are inert.
          req = !line_on || (enc_idx != mux_index_q);
        end
      end else begin
        sync_pending_d = sync_pending_q | sync_edge;
        if (entering) begin
          req            = 1'b1;
          req_tgt        = '0;
          sync_pending_d = 1'b0;
        end else if ((state_q == ST_ACTIVE) && bus.column_ready) begin
          // A sync edge in the same cycle as the pulse still counts.
          req            = 1'b1;
          req_tgt        = (sync_pending_q || sync_edge) ? '0 : next_idx;
          sync_pending_d = 1'b0;
        end
      end

      if (go_dark) begin
        state_d    = ST_ACTIVE;
        cnt_d      = '0;
        mux_out_d  = '0;
        blanking_d = 1'b0;
      end else if (req) begin
        state_d    = ST_BLANK;
        cnt_d      = '0;
        target_d   = req_tgt;
        mux_out_d  = '0;
        blanking_d = 1'b1;
      end else if (state_q == ST_BLANK) begin
        if (cnt_q == BLANK_TERM) begin
          state_d           = ST_ACTIVE;
          mux_out_d         = '0;
          mux_out_d[target_q] = 1'b1;
          mux_index_d       = target_q;
          blanking_d        = 1'b0;
          frame_start_d     = (cur_mode_q == MUX_AUTO) && (target_q == '0);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_OFF;
      cur_mode_q     <= MUX_OFF;
      cnt_q          <= '0;
      target_q       <= '0;
      sync_pending_q <= 1'b0;
      sync_q         <= 1'b0;
      mux_out_q      <= '0;
      mux_index_q    <= '0;
      blanking_q     <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_mode_q     <= cur_mode_d;
      cnt_q          <= cnt_d;
      target_q       <= target_d;
      sync_pending_q <= sync_pending_d;
      sync_q         <= sync_d;
      mux_out_q      <= mux_out_d;
      mux_index_q    <= mux_index_d;
      blanking_q     <= blanking_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign bus.mux_out     = mux_out_q;
  assign bus.mux_index   = mux_index_q;
  assign bus.blanking    = blanking_q;
  assign bus.frame_start = frame_start_q;
  assign bus.dbg_state   = state_q;

  // Never two lines at once, and never a lit line during the gap.
  a_onehot_no_overlap: assert property (
    @(posedge clk) disable iff (rst)
      $onehot0(mux_out_q) && (!line_on || !blanking_q)
  );

endmodule

// File: tb/tb_mux_sequencer.sv
module tb_mux_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mux_sequencer_if #(.NB_MUX(8)) bus();

  mux_sequencer #(
    .NB_MUX          (8),
    .BLANKING_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      tag;
    logic [1:0] mode;
    logic [7:0] sel;
    logic       cr;
    logic       ps;
    logic [7:0] emux;
    logic [2:0] eidx;
    logic       eblank;
    logic       efs;
  } vec_t;

  vec_t vec_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic void add(input string tag, input logic [1:0] mode, input logic [7:0] sel,
                              input logic cr, input logic ps, input logic [7:0] emux,
                              input logic [2:0] eidx, input logic eblank, input logic efs);
    vec_t v;
    v.tag = tag; v.mode = mode; v.sel = sel; v.cr = cr; v.ps = ps;
    v.emux = emux; v.eidx = eidx; v.eblank = eblank; v.efs = efs;
    vec_q.push_back(v);
  endfunction

  // One AUTO advance: pulse, 4 dark cycles, line ln lights, 5 hold cycles.
  function automatic void add_auto_step(input int ln, input logic ps, input int cr_blank_at);
    logic [7:0] m;
    m = 8'h01 << ln;
    add("step_go", 2'd2, 8'h00, 1'b1, ps, 8'h00, 3'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 3; k++)
      add("step_blank", 2'd2, 8'h00, (k == cr_blank_at), ps, 8'h00, 3'd0, 1'b1, 1'b0);
    add("step_on", 2'd2, 8'h00, 1'b0, ps, m, 3'(ln), 1'b0, (ln == 0));
    for (int k = 1; k <= 5; k++)
      add("step_hold", 2'd2, 8'h00, 1'b0, ps, m, 3'(ln), 1'b0, 1'b0);
  endfunction

  task automatic check(input string tag, input logic [7:0] emux, input logic [2:0] eidx,
                       input logic chk_idx, input logic eblank, input logic efs);
    n_vec++;
    if (bus.mux_out !== emux || (chk_idx && bus.mux_index !== eidx) ||
        bus.blanking !== eblank || bus.frame_start !== efs) begin
      n_bad++;
      $display("FAIL %s (vec %0d): got mux=%h idx=%0d blank=%b fs=%b, want mux=%h idx=%0d blank=%b fs=%b",
               tag, n_vec, bus.mux_out, bus.mux_index, bus.blanking, bus.frame_start,
               emux, eidx, eblank, efs);
    end
  endtask

  task automatic drive(input logic [1:0] mode, input logic [7:0] sel, input logic cr, input logic ps);
    bus.mode          = mode;
    bus.manual_sel    = sel;
    bus.column_ready  = cr;
    bus.position_sync = ps;
  endtask

  initial begin
    drive(2'd0, 8'h00, 1'b0, 1'b0);

    // ---- vector table ----
    for (int k = 0; k < 4; k++) add("auto_entry_blank", 2'd2, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0);
    add("auto_entry_on",   2'd2, 8'h00, 1'b0, 1'b0, 8'h01, 3'd0, 1'b0, 1'b1);
    add("auto_entry_hold", 2'd2, 8'h00, 1'b0, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0);
    // full revolution; on step 3 a pulse lands mid-gap and must be dropped
    for (int s = 1; s <= 8; s++) add_auto_step(s % 8, 1'b0, (s == 3) ? 1 : 0);
    for (int s = 1; s <= 5; s++) add_auto_step(s, 1'b0, 0);
    // sync rise at line 5, then the next pulse goes to line 0
    add("sync_rise", 2'd2, 8'h00, 1'b0, 1'b1, 8'h20, 3'd5, 1'b0, 1'b0);
    add("sync_hold", 2'd2, 8'h00, 1'b0, 1'b1, 8'h20, 3'd5, 1'b0, 1'b0);
    add_auto_step(0, 1'b1, 0);
    add("sync_low", 2'd2, 8'h00, 1'b0, 1'b0, 8'h01, 3'd0, 1'b0, 1'b0);
    add_auto_step(1, 1'b0, 0);
    // sync edge in the same cycle as the pulse
    add_auto_step(0, 1'b1, 0);
    // pending flag must be consumed: plain advance afterwards
    add_auto_step(1, 1'b1, 0);
    // MANUAL
    for (int k = 0; k < 4; k++) add("man_blank", 2'd1, 8'h60, 1'b0, 1'b1, 8'h00, 3'd0, 1'b1, 1'b0);
    add("man_on_20", 2'd1, 8'h60, 1'b0, 1'b1, 8'h20, 3'd5, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) add("man_hold_20", 2'd1, 8'h60, 1'b0, 1'b1, 8'h20, 3'd5, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) add("man_chg_blank", 2'd1, 8'h40, 1'b0, 1'b1, 8'h00, 3'd0, 1'b1, 1'b0);
    add("man_on_40", 2'd1, 8'h40, 1'b0, 1'b1, 8'h40, 3'd6, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) add("man_ignore_hi", 2'd1, 8'hC0, 1'b0, 1'b1, 8'h40, 3'd6, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) add("man_zero", 2'd1, 8'h00, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) add("man_from_dark", 2'd1, 8'h01, 1'b0, 1'b1, 8'h00, 3'd0, 1'b1, 1'b0);
    add("man_on_01", 2'd1, 8'h01, 1'b0, 1'b1, 8'h01, 3'd0, 1'b0, 1'b0);
    // OFF mid-gap, then reserved mode
    for (int k = 0; k < 2; k++) add("off_pre_blank", 2'd1, 8'h02, 1'b0, 1'b1, 8'h00, 3'd0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) add("off_mid_blank", 2'd0, 8'h02, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) add("mode_rsvd", 2'd3, 8'h02, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
    // MANUAL -> AUTO mid-gap: counter restarts, 4 full dark cycles
    for (int k = 0; k < 2; k++) add("m2a_pre_blank", 2'd1, 8'h04, 1'b0, 1'b1, 8'h00, 3'd0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) add("m2a_blank", 2'd2, 8'h04, 1'b0, 1'b1, 8'h00, 3'd0, 1'b1, 1'b0);
    add("m2a_on", 2'd2, 8'h04, 1'b0, 1'b1, 8'h01, 3'd0, 1'b0, 1'b1);
    add("m2a_hold", 2'd2, 8'h04, 1'b0, 1'b1, 8'h01, 3'd0, 1'b0, 1'b0);

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("reset_state", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    // ---- apply table ----
    foreach (vec_q[i]) begin
      drive(vec_q[i].mode, vec_q[i].sel, vec_q[i].cr, vec_q[i].ps);
      @(posedge clk);
      @(negedge clk);
      check(vec_q[i].tag, vec_q[i].emux, vec_q[i].eidx, (vec_q[i].emux != 8'h00),
            vec_q[i].eblank, vec_q[i].efs);
    end

    // ---- async reset between edges while a line is lit ----
    #2 rst = 1'b1;
    #1 check("async_rst_now", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("async_rst_held", 8'h00, 3'd0, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;

    // ---- random soak: structural invariants every cycle ----
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 199) == 0) bus.mode = 2'($urandom_range(0, 3));
      bus.column_ready = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) bus.position_sync = ~bus.position_sync;
      if ($urandom_range(0, 99) == 0) bus.manual_sel = 8'($urandom_range(0, 255));
      @(posedge clk);
      @(negedge clk);
      n_vec++;
      if (!$onehot0(bus.mux_out) || (bus.mux_out != 8'h00 && bus.blanking) ||
          (bus.mux_out != 8'h00 && bus.mux_out != (8'h01 << bus.mux_index)) ||
          (bus.frame_start && bus.mux_out != 8'h01)) begin
        n_bad++;
        $display("FAIL soak_invariant (cycle %0d): got mux=%h idx=%0d blank=%b fs=%b, want onehot0 mux matching idx, no lit line while blanking",
                 c, bus.mux_out, bus.mux_index, bus.blanking, bus.frame_start);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
